// File: rtl/serdes_tx_link_trainer_pkg.sv
// Shared definitions for the SERDES transmit link trainer: FSM state encoding,
// default training/alignment/idle words and a small state-class helper.
package serdes_tx_link_trainer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_TRAIN    = 3'd2,
    ST_SYNC     = 3'd3,
    ST_LINK     = 3'd4
  } link_state_e;

  localparam logic [9:0] DEF_TRAIN_WORD = 10'b1111100000;
  localparam logic [9:0] DEF_SYNC_WORD  = 10'b0011111010;
  localparam logic [9:0] DEF_IDLE_WORD  = 10'b1010101010;

  // States in which a word is driven into O_SERDES every clock.
  function automatic logic is_tx_state(link_state_e s);
    return (s == ST_TRAIN) || (s == ST_SYNC) || (s == ST_LINK);
  endfunction

endpackage

// File: rtl/serdes_tx_link_trainer_if.sv
// Payload handshake between user logic and the link trainer.
//   tx_data  : payload word
//   tx_valid : payload word valid
//   tx_ready : word accepted when tx_valid && tx_ready
// master = user logic (source), slave = link trainer (sink).
interface serdes_tx_link_trainer_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serdes_tx_link_trainer_sync_2ff.sv
// Two-flop synchroniser for the asynchronous far-end ready indication.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset, clears both flops
//   d_i    : asynchronous input
//   q_o    : synchronised output (two clocks of latency)
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serdes_tx_link_trainer.sv
// Fabric-side transmit controller for an O_SERDES: waits for PLL lock, trains the
// far-end I_SERDES with a fixed pattern, sends an alignment marker, then carries
// payload words with IDLE filler. Any loss of enable/lock/far-end ready, or a
// retrain request, falls back to the appropriate earlier phase.
//   clk_i        : word clock (O_SERDES fabric clock)
//   rst_ni       : synchronous active-low reset
//   en_i         : link enable
//   pll_lock_i   : PLL lock, clk_i domain
//   rx_ready_i   : far-end ready, asynchronous
//   retrain_i    : request to restart training
//   tx_if        : payload handshake (slave side)
//   d_out_o      : O_SERDES.D word, registered
//   data_valid_o : O_SERDES.DATA_VALID, registered
//   oe_o         : O_SERDES.OE_IN, registered
//   link_up_o    : high while in LINK, registered
//
// state    | meaning
// IDLE     | link disabled, outputs quiet
// WAIT_PLL | counting consecutive PLL lock cycles
// TRAIN    | sending TRAIN_WORD, waiting for minimum count and far-end ready
// SYNC     | sending SYNC_REPEAT alignment markers
// LINK     | carrying payload, IDLE_WORD when nothing offered
module serdes_tx_link_trainer
  import serdes_tx_link_trainer_pkg::*;
#(
  parameter int         WIDTH        = 10,
  parameter logic [9:0] TRAIN_WORD   = DEF_TRAIN_WORD,
  parameter logic [9:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter logic [9:0] IDLE_WORD    = DEF_IDLE_WORD,
  parameter int         TRAIN_CYCLES = 256,
  parameter int         SYNC_REPEAT  = 4,
  parameter int         PLL_WAIT     = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                pll_lock_i,
  input  logic                rx_ready_i,
  input  logic                retrain_i,
  serdes_tx_link_trainer_if.slave tx_if,
  output logic [WIDTH-1:0]    d_out_o,
  output logic                data_valid_o,
  output logic                oe_o,
  output logic                link_up_o
);

  localparam int TCW = $clog2(TRAIN_CYCLES + 1);

  localparam logic [WIDTH-1:0] TRAIN_W  = TRAIN_WORD[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SYNC_W   = SYNC_WORD[WIDTH-1:0];
  localparam logic [WIDTH-1:0] IDLE_W   = IDLE_WORD[WIDTH-1:0];
  localparam logic [TCW-1:0]   TRAIN_TC = TCW'(TRAIN_CYCLES);
  localparam logic [7:0]       PLL_TC   = 8'(PLL_WAIT);
  localparam logic [3:0]       SYNC_TC  = 4'(SYNC_REPEAT - 1);

  link_state_e      state_q, state_d;
  logic [7:0]       pll_cnt_q, pll_cnt_d;
  logic [TCW-1:0]   train_cnt_q, train_cnt_d, train_inc;
  logic [3:0]       sync_cnt_q, sync_cnt_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             data_valid_q, oe_q, link_up_q, tx_ready_q;
  logic             rx_ready_s;
  logic             xfer;

  sync_2ff u_rx_ready_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_ready_i),
    .q_o    (rx_ready_s)
  );

  // tx_ready_q is only ever set in LINK, so it alone qualifies a transfer.
  assign xfer = tx_if.tx_valid && tx_ready_q;

  // train_inc counts the TRAIN word being sent this cycle, saturating.
  assign train_inc = (train_cnt_q == TRAIN_TC) ? train_cnt_q : train_cnt_q + TCW'(1);

  always_comb begin
    state_d     = state_q;
    pll_cnt_d   = pll_cnt_q;
    train_cnt_d = train_cnt_q;
    sync_cnt_d  = sync_cnt_q;

    if (state_q == ST_IDLE) begin
      if (en_i) begin
        state_d   = ST_WAIT_PLL;
        pll_cnt_d = '0;
      end
    end else if (!en_i) begin
      state_d = ST_IDLE;
    end else if (!pll_lock_i) begin
      state_d   = ST_WAIT_PLL;
      pll_cnt_d = '0;
    end else if (retrain_i ||
                 (((state_q == ST_SYNC) || (state_q == ST_LINK)) && !rx_ready_s)) begin
      state_d     = ST_TRAIN;
      train_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_PLL: begin
          if (pll_cnt_q == PLL_TC) begin
            state_d     = ST_TRAIN;
            train_cnt_d = '0;
          end else begin
            pll_cnt_d = pll_cnt_q + 8'd1;
          end
        end
        ST_TRAIN: begin
          train_cnt_d = train_inc;
          if ((train_inc == TRAIN_TC) && rx_ready_s) begin
            state_d    = ST_SYNC;
            sync_cnt_d = '0;
          end
        end
        ST_SYNC: begin
          if (sync_cnt_q == SYNC_TC) begin
            state_d = ST_LINK;
          end else begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output word follows the state being entered, so an abort replaces any
  // payload accepted in the same cycle with the new state's word.
  always_comb begin
    d_out_d = '0;
    unique case (state_d)
      ST_TRAIN: d_out_d = TRAIN_W;
      ST_SYNC:  d_out_d = SYNC_W;
      ST_LINK:  d_out_d = xfer ? tx_if.tx_data : IDLE_W;
      default:  d_out_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pll_cnt_q    <= '0;
      train_cnt_q  <= '0;
      sync_cnt_q   <= '0;
      d_out_q      <= '0;
      data_valid_q <= 1'b0;
      oe_q         <= 1'b0;
      link_up_q    <= 1'b0;
      tx_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pll_cnt_q    <= pll_cnt_d;
      train_cnt_q  <= train_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      d_out_q      <= d_out_d;
      data_valid_q <= is_tx_state(state_d);
      oe_q         <= is_tx_state(state_d);
      link_up_q    <= (state_d == ST_LINK);
      tx_ready_q   <= (state_d == ST_LINK);
    end
  end

  assign d_out_o        = d_out_q;
  assign data_valid_o   = data_valid_q;
  assign oe_o           = oe_q;
  assign link_up_o      = link_up_q;
  assign tx_if.tx_ready = tx_ready_q;

endmodule

// File: tb/tb_serdes_tx_link_trainer.sv
module tb_serdes_tx_link_trainer;

  localparam int         W  = 10;
  localparam logic [W-1:0] TW = 10'b1111100000;
  localparam logic [W-1:0] SW = 10'b0011111010;
  localparam logic [W-1:0] IW = 10'b1010101010;
  localparam int TC = 256;
  localparam int SR = 4;
  localparam int PW = 255;

  // Reference model phases
  localparam int PH_QUIET = 100, PH_LOCKWAIT = 101, PH_TRAINING = 102,
                 PH_ALIGN = 103, PH_UP = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, pll_lock, rx_ready, retrain;
  logic [W-1:0] d_out;
  logic dv, oe, link_up;

  serdes_tx_link_trainer_if #(.WIDTH(W)) tx_if ();

  serdes_tx_link_trainer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .pll_lock_i   (pll_lock),
    .rx_ready_i   (rx_ready),
    .retrain_i    (retrain),
    .tx_if        (tx_if),
    .d_out_o      (d_out),
    .data_valid_o (dv),
    .oe_o         (oe),
    .link_up_o    (link_up)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: phase, consecutive-lock count, words emitted in current phase
  int m_mode = PH_QUIET;
  int m_pll = 0, m_tw = 0, m_sw = 0;
  bit m_rx1 = 0, m_rx2 = 0;
  logic [W-1:0] exp_d = '0;

  task automatic model_step();
    bit rxs, acc;
    int nxt;
    if (!rst_n) begin
      m_mode = PH_QUIET; m_pll = 0; m_tw = 0; m_sw = 0;
      m_rx1 = 0; m_rx2 = 0; exp_d = '0;
      return;
    end
    rxs = m_rx2; m_rx2 = m_rx1; m_rx1 = rx_ready;
    acc = (m_mode == PH_UP) && tx_if.tx_valid;
    nxt = m_mode;
    if (m_mode == PH_QUIET) begin
      if (en) begin nxt = PH_LOCKWAIT; m_pll = 0; end
    end else if (!en) begin
      nxt = PH_QUIET;
    end else if (!pll_lock) begin
      nxt = PH_LOCKWAIT; m_pll = 0;
    end else if (retrain || ((m_mode == PH_ALIGN || m_mode == PH_UP) && !rxs)) begin
      nxt = PH_TRAINING; m_tw = 1;
    end else if (m_mode == PH_LOCKWAIT) begin
      if (m_pll == PW) begin nxt = PH_TRAINING; m_tw = 1; end
      else m_pll++;
    end else if (m_mode == PH_TRAINING) begin
      if (m_tw >= TC && rxs) begin nxt = PH_ALIGN; m_sw = 1; end
      else m_tw++;
    end else if (m_mode == PH_ALIGN) begin
      if (m_sw == SR) nxt = PH_UP;
      else m_sw++;
    end
    if (nxt == PH_TRAINING)   exp_d = TW;
    else if (nxt == PH_ALIGN) exp_d = SW;
    else if (nxt == PH_UP)    exp_d = acc ? tx_if.tx_data : IW;
    else                      exp_d = '0;
    m_mode = nxt;
  endtask

  task automatic tick();
    logic up, act;
    @(posedge clk);
    model_step();
    #1;
    up  = (m_mode == PH_UP);
    act = (m_mode == PH_TRAINING || m_mode == PH_ALIGN || m_mode == PH_UP);
    n_checks++;
    if ({link_up, tx_if.tx_ready, oe, dv, d_out} !== {up, up, act, act, exp_d}) begin
      n_fail++;
      $display("FAIL model t=%0t got up=%b rdy=%b oe=%b dv=%b d=%h want up=%b rdy=%b oe=%b dv=%b d=%h",
               $time, link_up, tx_if.tx_ready, oe, dv, d_out, up, up, act, act, exp_d);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, got, want);
    end
  endtask

  task automatic count_words(input logic [W-1:0] w, output int n);
    n = 0;
    while (dv === 1'b1 && d_out === w && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic ticks_to_dv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (dv !== 1'b1 && n < 2000);
  endtask

  task automatic ticks_to_link(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (link_up !== 1'b1 && n < 2000);
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] data;
    logic [W-1:0] exp_d;
  } pay_vec_t;

  pay_vec_t pv [8];

  initial begin
    #5ms;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pv[0] = '{1'b1, 10'h155, 10'h155};
    pv[1] = '{1'b0, 10'h000, IW};
    pv[2] = '{1'b0, 10'h3FF, IW};
    pv[3] = '{1'b1, 10'h2AA, 10'h2AA};
    pv[4] = '{1'b1, 10'h3FF, 10'h3FF};
    pv[5] = '{1'b0, 10'h111, IW};
    pv[6] = '{1'b1, TW,      TW};
    pv[7] = '{1'b1, SW,      SW};

    rst_n = 1'b0; en = 1'b1; pll_lock = 1'b1; rx_ready = 1'b1; retrain = 1'b0;
    tx_if.tx_valid = 1'b0; tx_if.tx_data = '0;

    // Reset and bring-up
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_quiet", {18'd0, link_up, tx_if.tx_ready, oe, dv, d_out}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("left_idle_quiet", {31'd0, dv}, 32'd0);
    ticks_to_dv(n);
    chk("bringup_dv_delay", n, PW + 1);
    chk("bringup_first_word", d_out, TW);
    count_words(TW, n);
    chk("train_words", n, TC);
    count_words(SW, n);
    chk("sync_words", n, SR);
    chk("link_up_after_sync", {31'd0, link_up}, 32'd1);
    chk("idle_in_link", d_out, IW);

    // Payload table
    for (int i = 0; i < 8; i++) begin
      tx_if.tx_valid = pv[i].v;
      tx_if.tx_data  = pv[i].data;
      tick();
      chk($sformatf("payload_d[%0d]", i), d_out, pv[i].exp_d);
      chk($sformatf("payload_ready[%0d]", i), {31'd0, tx_if.tx_ready}, 32'd1);
    end
    tx_if.tx_valid = 1'b0;

    // PLL glitch in LINK
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    chk("pll_glitch_link_up", {31'd0, link_up}, 32'd0);
    chk("pll_glitch_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    chk("pll_glitch_dv", {31'd0, dv}, 32'd0);
    ticks_to_dv(n);
    chk("pll_restart_delay", n, PW + 1);
    count_words(TW, n);
    chk("pll_train_words", n, TC);
    count_words(SW, n);
    chk("pll_sync_words", n, SR);

    // RETRAIN pulse in LINK
    retrain = 1'b1;
    tick();
    retrain = 1'b0;
    chk("retrain_link_down", {31'd0, link_up}, 32'd0);
    count_words(TW, n);
    chk("retrain_train_words", n, TC);
    count_words(SW, n);
    chk("retrain_sync_words", n, SR);
    chk("retrain_link_up", {31'd0, link_up}, 32'd1);

    // Far-end ready drop in LINK, then held low
    rx_ready = 1'b0;
    tick(); tick();
    chk("rx_drop_sync_latency", {31'd0, link_up}, 32'd1);
    tick();
    chk("rx_drop_link_down", {31'd0, link_up}, 32'd0);
    chk("rx_drop_train_word", d_out, TW);
    for (int i = 0; i < 400; i++) tick();
    chk("rx_gate_hold_word", d_out, TW);
    chk("rx_gate_hold_link", {31'd0, link_up}, 32'd0);
    rx_ready = 1'b1;
    ticks_to_link(n);
    chk("rx_resume_to_link", n, 3 + SR);

    // EN=0 and PLL_LOCK=0 together -> IDLE
    en = 1'b0; pll_lock = 1'b0;
    tick();
    chk("prio_quiet", {18'd0, link_up, tx_if.tx_ready, oe, dv, d_out}, 32'd0);
    en = 1'b1; pll_lock = 1'b1;
    ticks_to_dv(n);
    chk("prio_from_idle", n, PW + 2);

    // Reset in the middle of SYNC
    count_words(TW, n);
    chk("pre_rst_sync_word", d_out, SW);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_sync_quiet", {18'd0, link_up, tx_if.tx_ready, oe, dv, d_out}, 32'd0);
    ticks_to_dv(n);
    chk("rst_mid_sync_restart", n, PW + 2);

    // Randomised epochs: a clean stretch reaching LINK, then disturbances
    for (int ep = 0; ep < 6; ep++) begin
      rst_n = 1'b1; en = 1'b1; pll_lock = 1'b1; rx_ready = 1'b1; retrain = 1'b0;
      for (int c = 0; c < 600; c++) begin
        tx_if.tx_valid = $urandom_range(0, 1) != 0;
        tx_if.tx_data  = W'($urandom);
        tick();
      end
      for (int c = 0; c < 300; c++) begin
        en       = $urandom_range(0, 199) != 0;
        pll_lock = $urandom_range(0, 99) != 0;
        retrain  = $urandom_range(0, 149) == 0;
        rst_n    = $urandom_range(0, 499) != 0;
        if ($urandom_range(0, 39) == 0) rx_ready = ~rx_ready;
        tx_if.tx_valid = $urandom_range(0, 1) != 0;
        tx_if.tx_data  = W'($urandom);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
